// File: rtl/sram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_wr_arbiter
// Brief    : Packet-level round-robin arbiter sharing one SRAM write path
//            between two write ports, with a one-stage output register.
// Revision : 1.0 - initial release
// ============================================================================
module sram_wr_arbiter #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_Wr_0_valid,
    input  logic [DATA_W-1:0] io_Wr_0_data,
    input  logic              io_Wr_0_sop,
    input  logic              io_Wr_0_eop,
    output logic              io_Wr_0_ready,
    input  logic              io_Wr_1_valid,
    input  logic [DATA_W-1:0] io_Wr_1_data,
    input  logic              io_Wr_1_sop,
    input  logic              io_Wr_1_eop,
    output logic              io_Wr_1_ready,
    output logic              io_Out_valid,
    output logic [DATA_W-1:0] io_Out_data,
    output logic              io_Out_sop,
    output logic              io_Out_eop,
    output logic              io_Out_src,
    output logic [LEN_W-1:0]  io_Out_len,
    input  logic              io_Out_ready,
    output logic              io_err
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_BUSY0  = 3'd1;
    localparam logic [2:0] c_BUSY1  = 3'd2;
    localparam logic [2:0] c_FLUSH0 = 3'd3;
    localparam logic [2:0] c_FLUSH1 = 3'd4;
    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_MAX = LEN_W'(MAX_LEN);

    logic [2:0]        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_src_q, out_src_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
    logic              err_q, err_d;

    logic              w_can_load, w_elig0, w_elig1, w_drop0, w_drop1, w_idle_win;
    logic              w_sel, w_grant, w_load, w_ld_sop, w_ld_eop, w_err;
    logic              w_s_valid, w_s_sop, w_s_eop;
    logic [DATA_W-1:0] w_s_data;
    logic [LEN_W-1:0]  w_ld_len, w_cnt_inc;

    assign w_can_load = !out_valid_q || io_Out_ready;
    assign w_elig0    = io_Wr_0_valid && io_Wr_0_sop;
    assign w_elig1    = io_Wr_1_valid && io_Wr_1_sop;
    assign w_drop0    = (state_q == c_IDLE) && io_Wr_0_valid && !io_Wr_0_sop;
    assign w_drop1    = (state_q == c_IDLE) && io_Wr_1_valid && !io_Wr_1_sop;
    // Port other than the last winner takes priority when both are eligible.
    assign w_idle_win = (w_elig0 && w_elig1) ? !rr_last_q : w_elig1;
    assign w_cnt_inc  = cnt_q + c_ONE;

    always_comb begin
        w_sel = w_idle_win;
        case (state_q)
            c_BUSY0, c_FLUSH0: w_sel = 1'b0;
            c_BUSY1, c_FLUSH1: w_sel = 1'b1;
            default:           w_sel = w_idle_win;
        endcase
    end

    assign w_s_valid = w_sel ? io_Wr_1_valid : io_Wr_0_valid;
    assign w_s_data  = w_sel ? io_Wr_1_data  : io_Wr_0_data;
    assign w_s_sop   = w_sel ? io_Wr_1_sop   : io_Wr_0_sop;
    assign w_s_eop   = w_sel ? io_Wr_1_eop   : io_Wr_0_eop;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        w_grant   = 1'b0;
        w_load    = 1'b0;
        w_ld_sop  = 1'b0;
        w_ld_eop  = 1'b0;
        w_ld_len  = '0;
        w_err     = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_grant  = w_can_load;
                    w_load   = w_can_load;
                    w_ld_sop = 1'b1;
                    w_ld_len = c_ONE;
                    if (w_can_load) begin
                        cnt_d = c_ONE;
                        if (w_s_eop) begin
                            w_ld_eop  = 1'b1;
                            rr_last_d = w_sel;
                        end else if (c_MAX == c_ONE) begin
                            w_ld_eop = 1'b1;
                            w_err    = 1'b1;
                            state_d  = w_sel ? c_FLUSH1 : c_FLUSH0;
                        end else begin
                            state_d = w_sel ? c_BUSY1 : c_BUSY0;
                        end
                    end
                end
            end
            c_BUSY0, c_BUSY1: begin
                w_grant = w_can_load;
                if (w_s_valid && w_can_load) begin
                    w_load   = 1'b1;
                    w_ld_len = w_cnt_inc;
                    cnt_d    = w_cnt_inc;
                    if (w_s_sop) begin
                        w_err = 1'b1;
                    end
                    if (w_s_eop) begin
                        w_ld_eop  = 1'b1;
                        rr_last_d = w_sel;
                        state_d   = c_IDLE;
                    end else if (w_cnt_inc == c_MAX) begin
                        // Truncate: close the packet downstream, swallow the rest.
                        w_ld_eop = 1'b1;
                        w_err    = 1'b1;
                        state_d  = w_sel ? c_FLUSH1 : c_FLUSH0;
                    end
                end
            end
            c_FLUSH0, c_FLUSH1: begin
                w_grant = 1'b1;
                if (w_s_valid && w_s_eop) begin
                    rr_last_d = w_sel;
                    state_d   = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
        if (w_drop0 || w_drop1) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_src_d   = out_src_q;
        out_len_d   = out_len_q;
        err_d       = w_err;
        if (w_can_load) begin
            out_valid_d = w_load;
            if (w_load) begin
                out_data_d = w_s_data;
                out_sop_d  = w_ld_sop;
                out_eop_d  = w_ld_eop;
                out_src_d  = w_sel;
                out_len_d  = w_ld_len;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= c_IDLE;
            rr_last_q   <= 1'b1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_src_q   <= 1'b0;
            out_len_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_src_q   <= out_src_d;
            out_len_q   <= out_len_d;
            err_q       <= err_d;
        end
    end

    // Ready is forced low while reset is held so no beat is consumed.
    assign io_Wr_0_ready = reset && ((w_grant && !w_sel) || w_drop0);
    assign io_Wr_1_ready = reset && ((w_grant && w_sel) || w_drop1);
    assign io_Out_valid  = out_valid_q;
    assign io_Out_data   = out_data_q;
    assign io_Out_sop    = out_sop_q;
    assign io_Out_eop    = out_eop_q;
    assign io_Out_src    = out_src_q;
    assign io_Out_len    = out_len_q;
    assign io_err        = err_q;
endmodule
`default_nettype wire
